// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Channel FSM state encoding and default debounce/hold lengths.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PWAIT   = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RWAIT   = 2'd3
  } btnState_e;

  localparam int unsigned DB_DEFAULT   = 500000;
  localparam int unsigned HOLD_DEFAULT = 50000000;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop sync, counter debounce, level/press/rel/tog/long.
// Ports: clk, rst_n (sync, active-low), keyN raw (0 = pressed), outputs.
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic keyN,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic tog,
  output logic long
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          sync1;
  logic          sync2;
  btnState_e     state;
  btnState_e     stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcntNext;
  logic          lvlNext;
  logic          pressNext;
  logic          relNext;
  logic          togNext;
  logic          longNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      lvl   <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      tog   <= 1'b0;
      long  <= 1'b0;
    end else begin
      sync1 <= ~keyN;
      sync2 <= sync1;
      state <= stateNext;
      cnt   <= cntNext;
      hcnt  <= hcntNext;
      lvl   <= lvlNext;
      press <= pressNext;
      rel   <= relNext;
      tog   <= togNext;
      long  <= longNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hcntNext  = hcnt;
    lvlNext   = lvl;
    togNext   = tog;
    pressNext = 1'b0;
    relNext   = 1'b0;
    longNext  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sync2) begin
          stateNext = ST_PWAIT;
          cntNext   = '0;
        end
      end
      ST_PWAIT: begin
        if (!sync2) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = ST_PRESSED;
          cntNext   = '0;
          hcntNext  = '0;
          lvlNext   = 1'b1;
          pressNext = 1'b1;
          togNext   = ~tog;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync2) begin
          stateNext = ST_RWAIT;
          cntNext   = '0;
        end else if (hcnt != HOLD_MAX) begin
          // hcnt counts held samples; it saturates so long fires once
          hcntNext = hcnt + 1'b1;
          longNext = (hcnt == HOLD_MAX - 1'b1);
        end
      end
      ST_RWAIT: begin
        if (sync2) begin
          // bounce back: hold time keeps accumulating
          stateNext = ST_PRESSED;
          cntNext   = '0;
          if (hcnt != HOLD_MAX) begin
            hcntNext = hcnt + 1'b1;
            longNext = (hcnt == HOLD_MAX - 1'b1);
          end
        end else if (cnt == CNT_LAST) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
          hcntNext  = '0;
          lvlNext   = 1'b0;
          relNext   = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N raw active-low push-buttons into clean level/pulse outputs.
// Ports: clk, rst_n (sync, active-low), key_n[N], lvl/press/rel/tog/long[N].
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N           = 2,
  parameter int unsigned DB_CYCLES   = DB_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] lvl,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] tog,
  output logic [N-1:0] long
);

  for (genvar i = 0; i < N; i++) begin : gCh
    button_conditioner_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) uCh (
      .clk  (clk),
      .rst_n(rst_n),
      .keyN (key_n[i]),
      .lvl  (lvl[i]),
      .press(press[i]),
      .rel  (rel[i]),
      .tog  (tog[i]),
      .long (long[i])
    );
  end

endmodule
